// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : mips_pkg                                                       |
// | Purpose   : Constants and types shared by the fetch unit and its prefetch  |
// |             FIFO: opcode/funct bit positions, reset PC default, PC step,   |
// |             fetch FSM state encoding and the FIFO entry layout.            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // Instruction field positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // Program counter
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_PASO      = 32'd4;

  // Fetch FSM state encoding
  localparam int ESTADO_W = 1;
  typedef logic [ESTADO_W-1:0] estado_t;
  localparam estado_t PEDIR    = 1'b0;  // normal fetching
  localparam estado_t DESCARTE = 1'b1;  // waiting to drop a stale response

  // Prefetch FIFO entry: address the word was fetched from, plus the word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entrada_t;

  // Branch targets are always word aligned; low two bits are discarded.
  function automatic logic [31:0] alinear(input logic [31:0] dir);
    return {dir[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_busqueda.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fifo_busqueda                                                  |
// | Purpose   : Synchronous prefetch FIFO of {pc, instr} entries with a        |
// |             synchronous flush. Head is presented combinationally from the  |
// |             storage registers and reads as zero when the FIFO is empty.    |
// | Ports     : clk, rst_n      clock / async active-low reset                 |
// |             flush          discard all entries (wins over push and pop)    |
// |             push, dato_in  write an entry                                  |
// |             pop            remove the head entry                           |
// |             cabeza         head entry (0 when empty)                       |
// |             vacia          FIFO empty                                      |
// |             cuenta         number of stored entries                        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fifo_busqueda
  import mips_pkg::*;
#(
  parameter int PROF = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entrada_t               dato_in,
  input  logic                   pop,
  output entrada_t               cabeza,
  output logic                   vacia,
  output logic [$clog2(PROF):0]  cuenta
);

  localparam int PTR_W = $clog2(PROF);
  localparam int CNT_W = PTR_W + 1;

  entrada_t             r_mem [PROF];
  logic [PTR_W-1:0]     r_wr;
  logic [PTR_W-1:0]     r_rd;
  logic [CNT_W-1:0]     r_cuenta;

  logic                 w_push;
  logic                 w_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign w_push = push && !flush && (r_cuenta != CNT_W'(PROF));
  assign w_pop  = pop  && !flush && (r_cuenta != '0);

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= dato_in;
    end
  end

  // PROF is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cuenta <= '0;
    end else if (flush) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cuenta <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cuenta <= r_cuenta + 1'b1;
        2'b01:   r_cuenta <= r_cuenta - 1'b1;
        default: r_cuenta <= r_cuenta;
      endcase
    end
  end

  always_comb begin
    cabeza = '0;
    if (r_cuenta != '0) begin
      cabeza = r_mem[r_rd];
    end
  end

  assign vacia  = (r_cuenta == '0);
  assign cuenta = r_cuenta;

endmodule
`default_nettype wire

// File: rtl/unidad_busqueda.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : unidad_busqueda                                                |
// | Purpose   : Instruction fetch unit. Requests words from instruction memory |
// |             over a req/ack handshake (at most one request outstanding),    |
// |             buffers them in a prefetch FIFO and presents the head to       |
// |             decode. A taken branch flushes the FIFO and redirects fetch;   |
// |             a request already in flight is completed and its data dropped. |
// | Ports     : clk, rst_n              clock / async active-low reset         |
// |             imem_req/addr/ack/rdata instruction memory handshake           |
// |             instr_valid/instr_ready decode handshake                       |
// |             instr, instruccion,     head word, opcode [31:26],             |
// |             campo_funcion, pc_actual funct [5:0], PC of head               |
// |             selFuentePc, dir_salto  branch taken pulse and target          |
// |             cnt_busq, cnt_desc      pushed / dropped word counters         |
// |                                     (only with BUSQ_CONTADORES_EN)         |
// | Config    : BUSQ_CONTADORES_EN - adds the fetch statistic counters          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module unidad_busqueda
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          PROF_BUF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  instruccion,
  output logic [5:0]  campo_funcion,
  output logic [31:0] pc_actual,
  input  logic        selFuentePc,
  input  logic [31:0] dir_salto
`ifdef BUSQ_CONTADORES_EN
  ,
  output logic [31:0] cnt_busq,
  output logic [31:0] cnt_desc
`endif
);

  localparam int CNT_W = $clog2(PROF_BUF) + 1;

  estado_t            r_estado;
  estado_t            w_estado_sig;
  logic [31:0]        r_pc;        // next address to fetch
  logic [31:0]        r_dir_desc;  // address of the request being dropped

  logic [CNT_W-1:0]   w_cuenta;
  logic               w_vacia;
  logic               w_libre;
  logic               w_push;
  logic               w_pop;
  entrada_t           w_cabeza;
  entrada_t           w_entrada;

  // A request is only issued when a FIFO slot is free, so a push can never
  // overflow even with a zero-wait memory.
  assign w_libre = (w_cuenta < CNT_W'(PROF_BUF));

  // Word is kept only in PEDIR and only if no redirect hits this same cycle.
  assign w_push    = (r_estado == PEDIR) && imem_req && imem_ack && !selFuentePc;
  assign w_pop     = instr_valid && instr_ready && !selFuentePc;
  assign w_entrada = '{pc: r_pc, instr: imem_rdata};

  // ---------------------------------------------------------------------------
  // Fetch FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= PEDIR;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      PEDIR: begin
        // Redirect while a request is pending and unanswered: the answer
        // will belong to the old stream and must be thrown away.
        if (selFuentePc && imem_req && !imem_ack) begin
          w_estado_sig = DESCARTE;
        end
      end
      DESCARTE: begin
        if (imem_ack) begin
          w_estado_sig = PEDIR;
        end
      end
      default: w_estado_sig = PEDIR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    case (r_estado)
      PEDIR: begin
        imem_req  = w_libre;
        imem_addr = r_pc;
      end
      DESCARTE: begin
        // The abandoned request stays on the bus until memory answers it.
        imem_req  = 1'b1;
        imem_addr = r_dir_desc;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
      end
    endcase
    // Reset is asynchronous, so the request must drop with it, not a cycle later.
    if (!rst_n) begin
      imem_req = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch PC and held address of the abandoned request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= PC_RESET;
      r_dir_desc <= PC_RESET;
    end else begin
      if (selFuentePc) begin
        r_pc <= alinear(dir_salto);
      end else if (w_push) begin
        r_pc <= r_pc + PC_PASO;  // 32-bit modulo wrap is intended
      end
      if ((r_estado == PEDIR) && (w_estado_sig == DESCARTE)) begin
        r_dir_desc <= r_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  fifo_busqueda #(
    .PROF    (PROF_BUF)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (selFuentePc),
    .push    (w_push),
    .dato_in (w_entrada),
    .pop     (w_pop),
    .cabeza  (w_cabeza),
    .vacia   (w_vacia),
    .cuenta  (w_cuenta)
  );

  assign instr_valid   = !w_vacia;
  assign instr         = w_cabeza.instr;
  assign instruccion   = w_cabeza.instr[OP_MSB:OP_LSB];
  assign campo_funcion = w_cabeza.instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_actual     = w_cabeza.pc;

`ifdef BUSQ_CONTADORES_EN
  // ---------------------------------------------------------------------------
  // Statistics: words kept, and words lost (stale answers plus flushed entries)
  // ---------------------------------------------------------------------------
  logic        w_dato_tirado;
  logic [31:0] w_desc_inc;

  assign w_dato_tirado = imem_req && imem_ack && ((r_estado == DESCARTE) || selFuentePc);

  always_comb begin
    w_desc_inc = 32'(w_dato_tirado);
    if (selFuentePc) begin
      w_desc_inc = w_desc_inc + 32'(w_cuenta);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_busq <= 32'd0;
      cnt_desc <= 32'd0;
    end else begin
      cnt_busq <= cnt_busq + 32'(w_push);
      cnt_desc <= cnt_desc + w_desc_inc;
    end
  end
`endif

endmodule
`default_nettype wire
